// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register feeding the 32-bit ALU. Resolves
//               MEM/WB operand forwarding at capture time and inserts one
//               bubble on a load-use hazard. It has a valid/ready handshake,
//               flush support and a saturating hazard-stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int RA_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    // decode-side handshake and operands
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RA_W-1:0]   in_rs1_addr,
    input  logic [RA_W-1:0]   in_rs2_addr,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_imm,
    input  logic [3:0]        in_alu_op,
    input  logic [RA_W-1:0]   in_rd_addr,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic              in_branch,
    // pipeline control
    input  logic              flush,
    input  logic              ex_ready,
    // forwarding and hazard sources
    input  logic              mem_fwd_valid,
    input  logic [RA_W-1:0]   mem_fwd_rd,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic              ex_is_load,
    input  logic [RA_W-1:0]   ex_rd,
    input  logic              wb_fwd_valid,
    input  logic [RA_W-1:0]   wb_fwd_rd,
    input  logic [XLEN-1:0]   wb_fwd_data,
    // execute-side outputs
    output logic              out_valid,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [XLEN-1:0]   out_store_data,
    output logic [3:0]        out_alu_op,
    output logic [RA_W-1:0]   out_rd_addr,
    output logic              out_reg_write,
    output logic              out_mem_read,
    output logic              out_mem_write,
    output logic              out_branch,
    output logic [CNT_W-1:0]  stall_count
);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic              valid_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   store_data_q;
    logic [3:0]        alu_op_q;
    logic [RA_W-1:0]   rd_addr_q;
    logic              reg_write_q;
    logic              mem_read_q;
    logic              mem_write_q;
    logic              branch_q;
    logic [CNT_W-1:0]  stall_count_q;
    logic [CNT_W-1:0]  stall_count_d;

    // ------------------------------------------------------------------------
    // Combinational decode of hazard, handshake and forwarding
    // ------------------------------------------------------------------------
    logic              use_rs2;
    logic              hazard;
    logic              capture;
    logic              stall_cycle;
    logic [XLEN-1:0]   fwd_rs1;
    logic [XLEN-1:0]   fwd_rs2;
    logic [XLEN-1:0]   b_d;

    // Register 0 reads as zero and never forwards; MEM is younger than WB, so it wins.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [RA_W-1:0] addr,
        input logic [XLEN-1:0] rf_data,
        input logic            m_valid,
        input logic [RA_W-1:0] m_rd,
        input logic [XLEN-1:0] m_data,
        input logic            w_valid,
        input logic [RA_W-1:0] w_rd,
        input logic [XLEN-1:0] w_data
    );
        logic [XLEN-1:0] res;
        if (addr == '0) begin
            res = '0;
        end else if (m_valid && (m_rd == addr)) begin
            res = m_data;
        end else if (w_valid && (w_rd == addr)) begin
            res = w_data;
        end else begin
            res = rf_data;
        end
        return res;
    endfunction

    // Hazard detection, ready generation and operand selection.
    always_comb begin
        // rs1 is always read; rs2 matters for register-register ops and stores.
        use_rs2     = ~in_use_imm | in_mem_write;
        hazard      = in_valid & ex_is_load & valid_q & (ex_rd != '0) &
                      ((in_rs1_addr == ex_rd) | (use_rs2 & (in_rs2_addr == ex_rd)));
        in_ready    = (~valid_q | ex_ready) & ~hazard & ~flush;
        capture     = in_valid & in_ready;
        stall_cycle = in_valid & ~in_ready & ~flush;

        fwd_rs1 = fwd_sel(in_rs1_addr, in_rs1_data, mem_fwd_valid, mem_fwd_rd,
                          mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        fwd_rs2 = fwd_sel(in_rs2_addr, in_rs2_data, mem_fwd_valid, mem_fwd_rd,
                          mem_fwd_data, wb_fwd_valid, wb_fwd_rd, wb_fwd_data);
        b_d     = in_use_imm ? in_imm : fwd_rs2;

        stall_count_d = stall_count_q;
        if (stall_cycle && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Pipeline register: flush beats capture, capture beats drain, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            store_data_q <= '0;
            alu_op_q     <= '0;
            rd_addr_q    <= '0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
        end else if (flush) begin
            // Data fields are left stale; only valid and side-effecting controls are killed.
            valid_q      <= 1'b0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            branch_q     <= 1'b0;
        end else if (capture) begin
            valid_q      <= 1'b1;
            a_q          <= fwd_rs1;
            b_q          <= b_d;
            store_data_q <= fwd_rs2;
            alu_op_q     <= in_alu_op;
            rd_addr_q    <= in_rd_addr;
            reg_write_q  <= in_reg_write;
            mem_read_q   <= in_mem_read;
            mem_write_q  <= in_mem_write;
            branch_q     <= in_branch;
        end else if (valid_q && ex_ready) begin
            valid_q      <= 1'b0;
        end
    end

    // Saturating count of cycles where decode was held off by a hazard or back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_a          = a_q;
    assign out_b          = b_q;
    assign out_store_data = store_data_q;
    assign out_alu_op     = alu_op_q;
    assign out_rd_addr    = rd_addr_q;
    assign out_reg_write  = reg_write_q;
    assign out_mem_read   = mem_read_q;
    assign out_mem_write  = mem_write_q;
    assign out_branch     = branch_q;
    assign stall_count    = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage: vector table, directed
//               hazard/hold/flush/saturation/reset sequences and a random
//               phase checked against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_op;
    logic        in_reg_write, in_mem_read, in_mem_write, in_branch;
    logic        flush, ex_ready;
    logic        mem_fwd_valid, wb_fwd_valid, ex_is_load;
    logic [4:0]  mem_fwd_rd, wb_fwd_rd, ex_rd;
    logic [31:0] mem_fwd_data, wb_fwd_data;
    logic        out_valid;
    logic [31:0] out_a, out_b, out_store_data;
    logic [3:0]  out_alu_op;
    logic [4:0]  out_rd_addr;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch;
    logic [15:0] stall_count;

    id_ex_stage #(.XLEN(32), .RA_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
        .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_branch(in_branch),
        .flush(flush), .ex_ready(ex_ready),
        .mem_fwd_valid(mem_fwd_valid), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_a(out_a), .out_b(out_b),
        .out_store_data(out_store_data), .out_alu_op(out_alu_op),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write),
        .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model of what the execute stage should see.
    bit          m_valid;
    logic [31:0] m_a, m_b, m_sd;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic [3:0]  m_ctl;      // {reg_write, mem_read, mem_write, branch}
    bit          m_ctl_zero; // controls known to be cleared (reset/flush, no capture since)
    int          m_cnt;

    typedef struct {
        logic [4:0]  r1a; logic [31:0] r1d;
        logic [4:0]  r2a; logic [31:0] r2d;
        logic [31:0] imm; logic use_imm; logic mw;
        logic mfv; logic [4:0] mfrd; logic [31:0] mfd;
        logic wfv; logic [4:0] wfrd; logic [31:0] wfd;
        logic [3:0]  op;
        logic [31:0] ea; logic [31:0] eb; logic [31:0] esd;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] rf);
        if (a == 5'd0) return 32'd0;
        if (mem_fwd_valid && mem_fwd_rd == a) return mem_fwd_data;
        if (wb_fwd_valid && wb_fwd_rd == a) return wb_fwd_data;
        return rf;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_a = 0; m_b = 0; m_sd = 0; m_op = 0; m_rd = 0;
        m_ctl = 0; m_ctl_zero = 1; m_cnt = 0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
        chk({tag, ".stall_count"}, {16'd0, stall_count}, m_cnt[31:0]);
        if (m_valid) begin
            chk({tag, ".a"}, out_a, m_a);
            chk({tag, ".b"}, out_b, m_b);
            chk({tag, ".store_data"}, out_store_data, m_sd);
            chk({tag, ".alu_op"}, {28'd0, out_alu_op}, {28'd0, m_op});
            chk({tag, ".rd"}, {27'd0, out_rd_addr}, {27'd0, m_rd});
        end
        if (m_valid || m_ctl_zero)
            chk({tag, ".ctl"}, {28'd0, out_reg_write, out_mem_read, out_mem_write, out_branch},
                {28'd0, m_ctl});
    endtask

    // One clock: inputs already driven; check ready, advance model, check outputs.
    task automatic tick(input string tag);
        bit reads_rs2, hz, rdy;
        #1;
        reads_rs2 = !in_use_imm || in_mem_write;
        hz  = in_valid && ex_is_load && m_valid && ex_rd != 0 &&
              (in_rs1_addr == ex_rd || (reads_rs2 && in_rs2_addr == ex_rd));
        rdy = (!m_valid || ex_ready) && !hz && !flush;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, rdy});
        if (in_valid && !rdy && !flush && m_cnt < 65535) m_cnt++;
        if (flush) begin
            m_valid = 0; m_ctl = 0; m_ctl_zero = 1;
        end else if (in_valid && rdy) begin
            m_valid = 1;
            m_a  = ref_fwd(in_rs1_addr, in_rs1_data);
            m_sd = ref_fwd(in_rs2_addr, in_rs2_data);
            m_b  = in_use_imm ? in_imm : m_sd;
            m_op = in_alu_op; m_rd = in_rd_addr;
            m_ctl = {in_reg_write, in_mem_read, in_mem_write, in_branch};
            m_ctl_zero = 0;
        end else if (m_valid && ex_ready) begin
            m_valid = 0;
        end
        @(posedge clk); #1;
        check_outs(tag);
    endtask

    task automatic drive_idle();
        in_valid = 0; in_rs1_addr = 0; in_rs2_addr = 0; in_rs1_data = 0; in_rs2_data = 0;
        in_imm = 0; in_use_imm = 0; in_alu_op = 0; in_rd_addr = 0;
        in_reg_write = 0; in_mem_read = 0; in_mem_write = 0; in_branch = 0;
        flush = 0; ex_ready = 1; mem_fwd_valid = 0; mem_fwd_rd = 0; mem_fwd_data = 0;
        ex_is_load = 0; ex_rd = 0; wb_fwd_valid = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
    endtask

    initial begin
        int c0;
        //        r1a   r1d           r2a   r2d           imm           ui mw mfv mfrd  mfd           wfv wfrd  wfd           op       ea            eb            esd
        vecs[0] = '{5'd3, 32'h10,       5'd4, 32'h20,       32'h0,        0, 0, 0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        4'b0010, 32'h10,       32'h20,       32'h20};
        vecs[1] = '{5'd5, 32'h1,        5'd6, 32'h2,        32'h0,        0, 0, 1, 5'd5, 32'hAA,       1, 5'd5, 32'hBB,       4'b0000, 32'hAA,       32'h2,        32'h2};
        vecs[2] = '{5'd0, 32'h123,      5'd0, 32'h456,      32'h0,        0, 0, 1, 5'd0, 32'hAA,       1, 5'd0, 32'hBB,       4'b1111, 32'h0,        32'h0,        32'h0};
        vecs[3] = '{5'd1, 32'h11,       5'd9, 32'h99,       32'h4,        1, 1, 1, 5'd9, 32'h55,       0, 5'd0, 32'h0,        4'b0010, 32'h11,       32'h4,        32'h55};
        vecs[4] = '{5'd8, 32'h80,       5'd8, 32'h81,       32'h0,        0, 0, 1, 5'd9, 32'hCC,       1, 5'd8, 32'hBB,       4'b0110, 32'hBB,       32'hBB,       32'hBB};
        vecs[5] = '{5'd2, 32'h22,       5'd8, 32'h81,       32'hFFFFFFF0, 1, 0, 1, 5'd8, 32'hCC,       1, 5'd8, 32'hBB,       4'b1000, 32'h22,       32'hFFFFFFF0, 32'hCC};
        vecs[6] = '{5'd4, 32'h44,       5'd4, 32'h45,       32'h0,        0, 0, 0, 5'd4, 32'hDD,       0, 5'd4, 32'hEE,       4'b0111, 32'h44,       32'h45,       32'h45};

        // Reset state
        drive_idle();
        in_valid = 1;
        rst_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset");
        chk("reset.a", out_a, 32'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        #2 rst_n = 1;

        // Table-driven single-cycle captures
        for (int i = 0; i < 7; i++) begin
            drive_idle();
            in_valid = 1; ex_ready = 1;
            in_rs1_addr = vecs[i].r1a; in_rs1_data = vecs[i].r1d;
            in_rs2_addr = vecs[i].r2a; in_rs2_data = vecs[i].r2d;
            in_imm = vecs[i].imm; in_use_imm = vecs[i].use_imm; in_mem_write = vecs[i].mw;
            mem_fwd_valid = vecs[i].mfv; mem_fwd_rd = vecs[i].mfrd; mem_fwd_data = vecs[i].mfd;
            wb_fwd_valid = vecs[i].wfv; wb_fwd_rd = vecs[i].wfrd; wb_fwd_data = vecs[i].wfd;
            in_alu_op = vecs[i].op; in_rd_addr = 5'(i + 10); in_reg_write = 1;
            tick($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_a", i), out_a, vecs[i].ea);
            chk($sformatf("vec%0d.tbl_b", i), out_b, vecs[i].eb);
            chk($sformatf("vec%0d.tbl_sd", i), out_store_data, vecs[i].esd);
            chk($sformatf("vec%0d.tbl_op", i), {28'd0, out_alu_op}, {28'd0, vecs[i].op});
        end

        // Load-use hazard: one bubble, then capture
        drive_idle();
        in_valid = 1; ex_ready = 1; ex_is_load = 1; ex_rd = 7;
        in_rs1_addr = 1; in_rs1_data = 32'h31; in_rs2_addr = 7; in_rs2_data = 32'h77;
        in_alu_op = 4'b0010; in_rd_addr = 12; in_reg_write = 1;
        c0 = m_cnt;
        tick("haz1");
        chk("haz.bubble", {31'd0, out_valid}, 32'd0);
        chk("haz.count", {16'd0, stall_count}, c0 + 1);
        tick("haz2");
        chk("haz.capture", {31'd0, out_valid}, 32'd1);
        chk("haz.capture_b", out_b, 32'h77);

        // Back-pressure hold for 3 cycles, then release
        drive_idle();
        in_valid = 1; ex_ready = 0;
        in_rs1_addr = 2; in_rs1_data = 32'hDEAD; in_rs2_addr = 3; in_rs2_data = 32'hBEEF;
        in_alu_op = 4'b0110; in_rd_addr = 13;
        c0 = m_cnt;
        for (int k = 0; k < 3; k++) tick($sformatf("hold%0d", k));
        chk("hold.a_unchanged", out_a, 32'h31);
        chk("hold.count", {16'd0, stall_count}, c0 + 3);
        ex_ready = 1;
        tick("hold_release");
        chk("hold_release.a", out_a, 32'hDEAD);

        // Flush while valid with an incoming instruction
        in_reg_write = 1; in_rs1_data = 32'h1234; flush = 1;
        c0 = m_cnt;
        tick("flush");
        chk("flush.reg_write", {31'd0, out_reg_write}, 32'd0);
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        chk("flush.no_stall_count", {16'd0, stall_count}, c0);
        flush = 0;

        // Random phase against the model
        for (int k = 0; k < 400; k++) begin
            in_valid      = ($urandom_range(0, 4) != 0);
            in_rs1_addr   = 5'($urandom_range(0, 3));
            in_rs2_addr   = 5'($urandom_range(0, 3));
            in_rs1_data   = $urandom;
            in_rs2_data   = $urandom;
            in_imm        = $urandom;
            in_use_imm    = 1'($urandom_range(0, 1));
            in_alu_op     = 4'($urandom);
            in_rd_addr    = 5'($urandom);
            in_reg_write  = 1'($urandom);
            in_mem_read   = 1'($urandom);
            in_mem_write  = 1'($urandom);
            in_branch     = 1'($urandom);
            flush         = ($urandom_range(0, 15) == 0);
            ex_ready      = ($urandom_range(0, 3) != 0);
            mem_fwd_valid = 1'($urandom);
            mem_fwd_rd    = 5'($urandom_range(0, 3));
            mem_fwd_data  = $urandom;
            wb_fwd_valid  = 1'($urandom);
            wb_fwd_rd     = 5'($urandom_range(0, 3));
            wb_fwd_data   = $urandom;
            ex_is_load    = 1'($urandom);
            ex_rd         = 5'($urandom_range(0, 3));
            tick($sformatf("rnd%0d", k));
        end

        // Stall-counter saturation
        drive_idle();
        in_valid = 1; ex_ready = 1; in_rs1_addr = 6; in_rs1_data = 32'h600D; in_reg_write = 1;
        tick("sat_fill");
        ex_ready = 0;
        repeat (65538) @(posedge clk);
        #1;
        m_cnt = 65535;
        chk("sat.count", {16'd0, stall_count}, 32'h0000FFFF);
        tick("sat_hold");

        // Asynchronous reset in the middle of a hold
        #2 rst_n = 0;
        #1;
        chk("areset.valid", {31'd0, out_valid}, 32'd0);
        chk("areset.count", {16'd0, stall_count}, 32'd0);
        chk("areset.reg_write", {31'd0, out_reg_write}, 32'd0);
        chk("areset.a", out_a, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        ex_ready = 1; in_rs1_data = 32'h7777;
        tick("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
